// File: rtl/lbist_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : lbist_reg_master
// Brief    : Sequences one LBIST session over a simple register bus.
//            Flow: configure, clear, go, poll done, read signature, stop.
// Revision : 1.0 - initial release
// ============================================================================
module lbist_reg_master #(
  parameter int POLL_GAP = 8
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        seq_start,
  input  logic [15:0] cfg_pat,
  input  logic [15:0] cfg_depth,
  input  logic [31:0] cfg_golden,
  input  logic [15:0] cfg_poll_max,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [1:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_pass,
  output logic        seq_fail,
  output logic        seq_timeout,
  output logic [31:0] seq_sig
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_CFG   = 4'd1,
    ST_WR_CLR   = 4'd2,
    ST_WR_GO    = 4'd3,
    ST_POLL_RD  = 4'd4,
    ST_POLL_GAP = 4'd5,
    ST_RD_SIG   = 4'd6,
    ST_WR_STOP  = 4'd7,
    ST_FINISH   = 4'd8
  } state_t;

  localparam logic [7:0] C_GAP_LAST = 8'(POLL_GAP - 1);

  state_t      r_state, w_state;
  logic        r_cs, w_cs, r_wr, w_wr;
  logic [1:0]  r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic        r_busy, w_busy, r_done, w_done;
  logic        r_pass, w_pass, r_fail, w_fail, r_timeout, w_timeout;
  logic [31:0] r_sig, w_sig;
  logic [15:0] r_pat, w_pat, r_depth, w_depth, r_pmax, w_pmax;
  logic [31:0] r_golden, w_golden;
  logic [15:0] r_pcnt, w_pcnt, w_pcnt_inc;
  logic [7:0]  r_gap, w_gap;
  logic        w_acked, w_bus_req, w_req_wr;
  logic [1:0]  w_req_addr;
  logic [31:0] w_req_data;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cs      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= 2'd0;
      r_wdata   <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_sig     <= 32'd0;
      r_pat     <= 16'd0;
      r_depth   <= 16'd0;
      r_pmax    <= 16'd0;
      r_golden  <= 32'd0;
      r_pcnt    <= 16'd0;
      r_gap     <= 8'd0;
    end else begin
      r_state   <= w_state;
      r_cs      <= w_cs;
      r_wr      <= w_wr;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_pass    <= w_pass;
      r_fail    <= w_fail;
      r_timeout <= w_timeout;
      r_sig     <= w_sig;
      r_pat     <= w_pat;
      r_depth   <= w_depth;
      r_pmax    <= w_pmax;
      r_golden  <= w_golden;
      r_pcnt    <= w_pcnt;
      r_gap     <= w_gap;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cs       = r_cs;
    w_wr       = r_wr;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_pass     = r_pass;
    w_fail     = r_fail;
    w_timeout  = r_timeout;
    w_sig      = r_sig;
    w_pat      = r_pat;
    w_depth    = r_depth;
    w_pmax     = r_pmax;
    w_golden   = r_golden;
    w_pcnt     = r_pcnt;
    w_gap      = r_gap;
    w_bus_req  = 1'b0;
    w_req_wr   = 1'b0;
    w_req_addr = 2'd0;
    w_req_data = 32'd0;
    w_acked    = r_cs & reg_ack;
    w_pcnt_inc = (r_pcnt == 16'hFFFF) ? r_pcnt : r_pcnt + 16'd1;

    case (r_state)
      ST_IDLE: begin
        if (seq_start) begin
          w_pass    = 1'b0;
          w_fail    = 1'b0;
          w_timeout = 1'b0;
          w_sig     = 32'd0;
          w_busy    = 1'b1;
          w_pat     = cfg_pat;
          w_depth   = cfg_depth;
          w_golden  = cfg_golden;
          w_pmax    = cfg_poll_max;
          w_state   = ST_WR_CFG;
        end
      end
      ST_WR_CFG: begin
        w_bus_req  = 1'b1;
        w_req_wr   = 1'b1;
        w_req_addr = 2'd1;
        w_req_data = {r_pat, r_depth};
        if (w_acked) w_state = ST_WR_CLR;
      end
      ST_WR_CLR: begin
        w_bus_req  = 1'b1;
        w_req_wr   = 1'b1;
        if (w_acked) w_state = ST_WR_GO;
      end
      ST_WR_GO: begin
        w_bus_req  = 1'b1;
        w_req_wr   = 1'b1;
        w_req_data = 32'h3;
        if (w_acked) begin
          w_pcnt  = 16'd0;
          w_state = ST_POLL_RD;
        end
      end
      ST_POLL_RD: begin
        w_bus_req = 1'b1;
        if (w_acked) begin
          w_pcnt = w_pcnt_inc;
          if (reg_rdata[31]) begin
            w_state = ST_RD_SIG;
          end else if (r_pmax != 16'd0 && w_pcnt_inc == r_pmax) begin
            w_timeout = 1'b1;
            w_state   = ST_WR_STOP;
          end else begin
            w_gap   = 8'd0;
            w_state = ST_POLL_GAP;
          end
        end
      end
      ST_POLL_GAP: begin
        // Raise cs on the last gap edge so the idle stretch is exactly POLL_GAP.
        if (r_gap == C_GAP_LAST) begin
          w_cs    = 1'b1;
          w_wr    = 1'b0;
          w_addr  = 2'd0;
          w_wdata = 32'd0;
          w_state = ST_POLL_RD;
        end else begin
          w_gap = r_gap + 8'd1;
        end
      end
      ST_RD_SIG: begin
        w_bus_req  = 1'b1;
        w_req_addr = 2'd2;
        if (w_acked) begin
          w_sig   = reg_rdata;
          w_pass  = (reg_rdata == r_golden);
          w_fail  = (reg_rdata != r_golden);
          w_state = ST_WR_STOP;
        end
      end
      ST_WR_STOP: begin
        w_bus_req  = 1'b1;
        w_req_wr   = 1'b1;
        w_req_data = 32'h1;
        if (w_acked) begin
          w_done  = 1'b1;
          w_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_busy  = 1'b0;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase

    // Entering a bus state leaves cs low one cycle before the request opens.
    if (w_acked) begin
      w_cs = 1'b0;
    end else if (w_bus_req && !r_cs) begin
      w_cs    = 1'b1;
      w_wr    = w_req_wr;
      w_addr  = w_req_addr;
      w_wdata = w_req_data;
    end
  end

  assign reg_cs      = r_cs;
  assign reg_wr      = r_wr;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_be      = 4'hF;
  assign seq_busy    = r_busy;
  assign seq_done    = r_done;
  assign seq_pass    = r_pass;
  assign seq_fail    = r_fail;
  assign seq_timeout = r_timeout;
  assign seq_sig     = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_lbist_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbist_reg_master
// Brief    : Scoreboard bench with a latency-configurable register responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbist_reg_master;
  localparam int GAP = 5;

  logic        mclk = 1'b0, reset_n = 1'b0, seq_start = 1'b0;
  logic [15:0] cfg_pat = '0, cfg_depth = '0, cfg_poll_max = '0;
  logic [31:0] cfg_golden = '0;
  logic        reg_cs, reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        seq_busy, seq_done, seq_pass, seq_fail, seq_timeout;
  logic [31:0] seq_sig;

  lbist_reg_master #(.POLL_GAP(GAP)) dut (
    .mclk(mclk), .reset_n(reset_n), .seq_start(seq_start),
    .cfg_pat(cfg_pat), .cfg_depth(cfg_depth), .cfg_golden(cfg_golden),
    .cfg_poll_max(cfg_poll_max), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_pass(seq_pass), .seq_fail(seq_fail),
    .seq_timeout(seq_timeout), .seq_sig(seq_sig)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  txn_t        e;
  int          n_cmp = 0, n_err = 0;
  int          ack_lat = 1, done_at = 0, poll_n = 0, wcnt = 0, lowcnt = 100, done_cnt = 0;
  logic [31:0] resp_sig = '0;
  logic        prev_rd0 = 1'b0, unstable = 1'b0;

  // Responder: acks after ack_lat cycles, checks bus stability, gaps and order.
  initial begin : responder
    forever begin
      @(negedge mclk);
      if (seq_done) done_cnt++;
      if (reg_ack) begin
        reg_ack = 1'b0;
        if (!reg_cs) lowcnt++;
      end else if (reg_cs) begin
        if (wcnt == 0) begin
          cur = '{reg_wr, reg_addr, reg_wdata};
          unstable = 1'b0;
          n_cmp++;
          if (prev_rd0 && !reg_wr && reg_addr == 2'd0) begin
            if (lowcnt != GAP) begin
              n_err++;
              $display("FAIL poll_gap: idle cycles %0d, required %0d", lowcnt, GAP);
            end
          end else if (lowcnt < 1) begin
            n_err++;
            $display("FAIL cs_low_gap: idle cycles %0d, required >= 1", lowcnt);
          end
          lowcnt = 0;
        end else if ({reg_wr, reg_addr, reg_wdata} !== cur) begin
          unstable = 1'b1;
        end
        wcnt++;
        if (wcnt >= ack_lat) begin
          wcnt = 0;
          reg_ack = 1'b1;
          reg_rdata = 32'd0;
          if (!reg_wr && reg_addr == 2'd0) begin
            poll_n++;
            reg_rdata[31] = (done_at != 0 && poll_n >= done_at);
          end else if (!reg_wr && reg_addr == 2'd2) begin
            reg_rdata = resp_sig;
          end
          prev_rd0 = (!reg_wr && reg_addr == 2'd0);
          n_cmp++;
          if (unstable || {reg_wr, reg_addr, reg_wdata} !== cur) begin
            n_err++;
            $display("FAIL bus_stable: bus %h, held-from-cs %h", {reg_wr, reg_addr, reg_wdata}, cur);
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_txn: got %h, required none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur.wr !== e.wr || cur.addr !== e.addr || (e.wr && cur.data !== e.data)) begin
              n_err++;
              $display("FAIL txn_order: got wr=%b addr=%0d data=%h, required wr=%b addr=%0d data=%h",
                       cur.wr, cur.addr, cur.data, e.wr, e.addr, e.data);
            end
          end
        end
      end else begin
        lowcnt++;
      end
    end
  end

  task automatic assert_reset();
    reset_n = 1'b0;
    exp_q.delete();
    reg_ack = 1'b0;
    wcnt = 0;
    lowcnt = 100;
    prev_rd0 = 1'b0;
  endtask

  task automatic start_session(input logic [15:0] pat, input logic [15:0] depth,
                               input logic [31:0] gold, input logic [15:0] pmax,
                               input int d_at, input logic [31:0] sig);
    int np;
    bit with_sig;
    cfg_pat = pat; cfg_depth = depth; cfg_golden = gold; cfg_poll_max = pmax;
    done_at = d_at; resp_sig = sig; poll_n = 0;
    with_sig = (d_at != 0 && (pmax == 16'd0 || d_at <= int'(pmax)));
    np = with_sig ? d_at : int'(pmax);
    exp_q.push_back('{1'b1, 2'd1, {pat, depth}});
    exp_q.push_back('{1'b1, 2'd0, 32'h0});
    exp_q.push_back('{1'b1, 2'd0, 32'h3});
    for (int i = 0; i < np; i++) exp_q.push_back('{1'b0, 2'd0, 32'h0});
    if (with_sig) exp_q.push_back('{1'b0, 2'd2, 32'h0});
    exp_q.push_back('{1'b1, 2'd0, 32'h1});
    seq_start = 1'b1;
    @(negedge mclk);
    seq_start = 1'b0;
    cfg_pat = ~pat; cfg_depth = ~depth; cfg_golden = ~gold; cfg_poll_max = pmax + 16'd1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (seq_done !== 1'b1 && i < 4000) begin
      @(negedge mclk);
      i++;
    end
    n_cmp++;
    if (seq_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_wait: seq_done=0 after %0d cycles, required 1", tag, i);
    end
  endtask

  // One full session at a given ack latency with result and completion checks.
  task automatic run_and_check(input string tag, input int lat, input logic [31:0] sig,
                               input logic [15:0] pmax, input int d_at,
                               input logic [2:0] exp_res, input logic [31:0] exp_sig);
    int d0;
    ack_lat = lat;
    d0 = done_cnt;
    start_session(16'h0010, 16'h0008, 32'hDEADBEEF, pmax, d_at, sig);
    n_cmp++;
    if (seq_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_start: %b, required 1", tag, seq_busy);
    end
    wait_done(tag);
    n_cmp++;
    if ({seq_pass, seq_fail, seq_timeout} !== exp_res) begin
      n_err++;
      $display("FAIL %s result pass/fail/timeout: %b, required %b", tag,
               {seq_pass, seq_fail, seq_timeout}, exp_res);
    end
    n_cmp++;
    if (seq_sig !== exp_sig) begin
      n_err++;
      $display("FAIL %s seq_sig: %h, required %h", tag, seq_sig, exp_sig);
    end
    @(negedge mclk);
    n_cmp++;
    if (seq_busy !== 1'b0 || seq_done !== 1'b0 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL %s completion: busy=%b done=%b pulses=%0d, required 0 0 1", tag,
               seq_busy, seq_done, done_cnt - d0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_txns: %0d left, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (3) @(negedge mclk);
    n_cmp++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy, seq_done, seq_pass,
         seq_fail, seq_timeout, seq_sig} !== {8'h00, 32'h0, 4'hF, 5'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: cs=%b wr=%b addr=%0d wdata=%h be=%h busy=%b done=%b sig=%h, required be=F rest 0",
               reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy, seq_done, seq_sig);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);
  endtask

  task automatic test_pass();    run_and_check("pass", 1, 32'hDEADBEEF, 16'd0, 3, 3'b100, 32'hDEADBEEF); endtask
  task automatic test_fail();    run_and_check("fail", 1, 32'hDEADBEEE, 16'd0, 3, 3'b010, 32'hDEADBEEE); endtask
  task automatic test_timeout(); run_and_check("timeout", 1, 32'h0, 16'd4, 0, 3'b001, 32'h0); endtask

  task automatic test_latency();
    run_and_check("lat2", 2, 32'hDEADBEEF, 16'd0, 3, 3'b100, 32'hDEADBEEF);
    run_and_check("lat7", 7, 32'hDEADBEEF, 16'd0, 3, 3'b100, 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back();
    ack_lat = 1;
    start_session(16'h0010, 16'h0008, 32'hDEADBEEF, 16'd0, 3, 32'hDEADBEEF);
    wait_done("b2b_a");
    seq_start = 1'b1;
    @(negedge mclk);
    seq_start = 1'b0;
    repeat (30) @(negedge mclk);
    n_cmp++;
    if (seq_busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL finish_start_ignored: busy=%b queued=%0d, required 0 0", seq_busy, exp_q.size());
    end
    start_session(16'h0010, 16'h0008, 32'hDEADBEEF, 16'd0, 2, 32'hDEADBEEF);
    wait_done("b2b_b");
    @(negedge mclk);
    run_and_check("b2b_c", 1, 32'hDEADBEEE, 16'd0, 1, 3'b010, 32'hDEADBEEE);
  endtask

  task automatic test_gap_start_and_reset();
    int i;
    ack_lat = 1;
    start_session(16'h0010, 16'h0008, 32'hDEADBEEF, 16'd6, 0, 32'h0);
    i = 0;
    while (poll_n < 2 && i < 500) begin @(negedge mclk); i++; end
    @(negedge mclk);
    seq_start = 1'b1;
    @(negedge mclk);
    seq_start = 1'b0;
    wait_done("gap_start");
    n_cmp++;
    if ({seq_pass, seq_fail, seq_timeout} !== 3'b001 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL gap_start_ignored: result=%b queued=%0d, required 001 0",
               {seq_pass, seq_fail, seq_timeout}, exp_q.size());
    end
    repeat (2) @(negedge mclk);
    ack_lat = 7;
    start_session(16'h0010, 16'h0008, 32'hDEADBEEF, 16'd0, 3, 32'hDEADBEEF);
    i = 0;
    while (!(reg_cs && reg_wr && reg_addr == 2'd0 && reg_wdata == 32'h3) && i < 500) begin
      @(negedge mclk); i++;
    end
    @(negedge mclk);
    #1 assert_reset();
    #1;
    n_cmp++;
    if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy, seq_done, seq_pass,
         seq_fail, seq_timeout, seq_sig} !== {8'h00, 32'h0, 4'hF, 5'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid_txn: cs=%b wr=%b addr=%0d wdata=%h be=%h busy=%b, required be=F rest 0",
               reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy);
    end
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);
    run_and_check("after_reset", 1, 32'hDEADBEEF, 16'd0, 3, 3'b100, 32'hDEADBEEF);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_latency();
    test_back_to_back();
    test_gap_start_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lbist_reg_master.md
LBIST_REG_MASTER -- requirements
Module: lbist_reg_master

Interface
REQ-001 Parameter POLL_GAP, default 8: idle mclk cycles between consecutive status-poll reads (legal range 1..255).
REQ-002 mclk  in  1  sole clock; every flop is rising-edge mclk.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 seq_start  in  1  single-cycle request to run one LBIST session; sampled in IDLE only.
REQ-005 cfg_pat  in  16  scan pattern count, written to LBIST reg-1[31:16].
REQ-006 cfg_depth  in  16  scan chain depth, written to LBIST reg-1[15:0].
REQ-007 cfg_golden  in  32  expected signature.
REQ-008 cfg_poll_max  in  16  maximum status polls before timeout; 0 means no limit.
REQ-009 reg_cs  out  1  bus request to LBIST register responder.
REQ-010 reg_wr  out  1  1 = write, 0 = read.
REQ-011 reg_addr  out  2  0 = control/status, 1 = pattern/depth, 2 = signature.
REQ-012 reg_wdata  out  32  write data.
REQ-013 reg_be  out  4  byte enables; always 4'hF.
REQ-014 reg_rdata  in  32  read data, valid in the cycle reg_ack = 1.
REQ-015 reg_ack  in  1  one-cycle acknowledge from the responder.
REQ-016 seq_busy  out  1  high from seq_start acceptance until seq_done.
REQ-017 seq_done  out  1  one-cycle pulse at session end.
REQ-018 seq_pass / seq_fail / seq_timeout  out  1 each  session result, held until the next accepted seq_start.
REQ-019 seq_sig  out  32  captured signature, held until the next accepted seq_start.

Function
REQ-020 The FSM states SHALL be IDLE, WR_CFG, WR_CLR, WR_GO, POLL_RD, POLL_GAP, RD_SIG, WR_STOP, FINISH.
REQ-021 Bus rule: reg_cs, reg_wr, reg_addr and reg_wdata SHALL be driven from flops and held stable from cs assertion through the cycle reg_ack = 1.
REQ-022 reg_cs SHALL deassert on the edge at which reg_ack = 1 is sampled; it SHALL be low for at least one cycle between transactions.
REQ-023 The block SHALL tolerate any ack latency of 1 cycle or more; reg_ack seen while reg_cs = 0 SHALL be ignored.
REQ-024 IDLE + seq_start: clear pass/fail/timeout/seq_sig, set seq_busy, and enter WR_CFG.
REQ-025 WR_CFG: write addr 1, data {cfg_pat, cfg_depth}, with cfg values latched at start acceptance; on ack go to WR_CLR.
REQ-026 WR_CLR: write addr 0, data 32'h0 (LBIST reset asserted, start low); on ack go to WR_GO.
REQ-027 WR_GO: write addr 0, data 32'h3 (reset released, start high); on ack clear the poll counter and go to POLL_RD.
REQ-028 POLL_RD: read addr 0; on ack increment the 16-bit poll counter.
REQ-029 On POLL_RD ack: if rdata[31] = 1, go to RD_SIG; else if cfg_poll_max != 0 and the counter equals cfg_poll_max, set seq_timeout and go to WR_STOP; otherwise go to POLL_GAP.
REQ-030 POLL_GAP: wait exactly POLL_GAP cycles with reg_cs low, then return to POLL_RD.
REQ-031 The poll counter SHALL saturate at 16'hFFFF and never wrap.
REQ-032 RD_SIG: read addr 2; on ack capture rdata into seq_sig and set seq_pass = (rdata == cfg_golden latched) and seq_fail = its inverse; then go to WR_STOP.
REQ-033 WR_STOP: write addr 0, data 32'h1 (start cleared, reset released); on ack go to FINISH.
REQ-034 FINISH: pulse seq_done for one cycle, clear seq_busy, and return to IDLE.
REQ-035 On timeout, seq_pass = 0 and seq_fail = 0.
REQ-036 seq_start while not in IDLE SHALL be ignored, including in the FINISH cycle.
REQ-037 seq_start in the cycle after FINISH SHALL be accepted normally.
REQ-038 Changes on cfg_* after acceptance SHALL have no effect on the running session.

Reset
REQ-039 Asynchronous assertion of reset_n SHALL force IDLE, with reg_cs = 0, reg_wr = 0, reg_addr = 0, reg_wdata = 0, and reg_be = 4'hF.
REQ-040 Reset SHALL also clear seq_busy, seq_done, seq_pass, seq_fail, seq_timeout, seq_sig, and all counters.
REQ-041 Reset during an open bus transaction SHALL drop reg_cs immediately; no transaction is resumed after reset.

Verification
REQ-042 Pass case: start with pat = 16'h0010, depth = 16'h0008, golden = 32'hDEADBEEF; responder sets done on the 3rd poll and signature 32'hDEADBEEF. Required: writes 0x00100008 @1, 0x0 @0, 0x3 @0; 3 reads @0; 1 read @2; write 0x1 @0; seq_pass = 1; one seq_done pulse.
REQ-043 Fail case: same setup with signature 32'hDEADBEEE. Required: seq_fail = 1, seq_pass = 0, seq_sig = 32'hDEADBEEE.
REQ-044 Timeout: cfg_poll_max = 4, done never set. Required: exactly 4 polls, each separated by POLL_GAP idle cycles; seq_timeout = 1; then write 0x1 @0 and seq_done.
REQ-045 Ack latency sweep 1, 2 and 7 cycles. Required: cs/addr/wdata stable until ack; cs low for at least 1 cycle between transactions; identical transaction sequence in all cases.
REQ-046 seq_start pulsed during POLL_GAP, then reset asserted mid-WR_GO. Required: the start is ignored; after reset all outputs are 0 except reg_be = 4'hF; a new start runs a full session from WR_CFG.
